mealy_event_logger: RTL and testbench

Downstream consumer of the Mealy sequence detector. Each cycle the detector asserts its detection, the logger records the detector's present state and a free-running cycle timestamp in a small FIFO and bumps a saturating event counter. Software or the bench drains the FIFO through a first-word-fall-through read port. Together these give an off-chip observer a loss-aware history of detections.

---
 rtl/mealy_logger_pkg.sv | 30 +++
 rtl/mealy_event_logger_if.sv | 27 ++
 rtl/mealy_event_logger_sync_fifo.sv | 61 ++++++
 rtl/mealy_event_logger.sv | 67 ++++++
 tb/tb_mealy_event_logger.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mealy_logger_pkg.sv
// Shared types for the Mealy detection logger: detector state codes and log entry layout.
package mealy_logger_pkg;

  // Default timestamp width of a logged entry.
  localparam int LOG_TS_W = 5;
  localparam int ENTRY_W  = 3 + LOG_TS_W;

  // Detector state encodings y[3:1].
  typedef enum logic [2:0] {
    ST_A = 3'b000,
    ST_B = 3'b001,
    ST_C = 3'b011,
    ST_D = 3'b010,
    ST_E = 3'b100
  } det_state_e;

  // One log record, packed as {state, timestamp}.
  typedef struct packed {
    logic [2:0]          state;
    logic [LOG_TS_W-1:0] ts;
  } entry_t;

  function automatic entry_t make_entry(logic [2:0] state, logic [LOG_TS_W-1:0] ts);
    entry_t e;
    e.state = state;
    e.ts    = ts;
    return e;
  endfunction

endpackage

// File: rtl/mealy_event_logger_if.sv
// Detector-facing and read-port signals of the event logger.
interface mealy_event_logger_if #(
  parameter int TS_W  = 5,
  parameter int CNT_W = 8
);
  logic              z_det;
  logic [2:0]        det_state;
  logic              clear;
  logic              rd_en;
  logic [3+TS_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  evt_count;

  // Driver side: detector plus the software/bench reader.
  modport master (
    output z_det, det_state, clear, rd_en,
    input  rd_data, empty, full, overflow, evt_count
  );

  // Logger side.
  modport slave (
    input  z_det, det_state, clear, rd_en,
    output rd_data, empty, full, overflow, evt_count
  );
endinterface

// File: rtl/mealy_event_logger_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_do;
  logic             pop_do;

  // Accepted transfers: a pop needs data, a push needs room or a same-cycle pop; clear blocks both.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it holding a value (no latch).
    pop_do  = 1'b0;
    push_do = 1'b0;
    if (!clear) begin
      pop_do  = pop & ~empty;
      push_do = push & (~full | pop_do);
    end
  end

  // Pointer state; clear rewinds both pointers to the reset position.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_do)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; rd_data is masked while empty, so stale words never leak.
  always_ff @(posedge clk) begin
    if (push_do) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mealy_event_logger.sv
// Logs each detector hit as {state, timestamp} into a FWFT FIFO, with a saturating hit
// counter and a sticky flag for hits dropped because the FIFO was full.
module mealy_event_logger
  import mealy_logger_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 5,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  mealy_event_logger_if.slave  bus
);
  localparam int               EW      = 3 + TS_W;
  localparam logic [TS_W-1:0]  TS_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] evt_cnt;
  logic             ovf;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_rd_data;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.clear),
    .push    (bus.z_det),
    .wr_data ({bus.det_state, ts}),
    .pop     (bus.rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Free-running timestamp; wraps naturally at 2^TS_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ts <= '0;
    else if (bus.clear) ts <= '0;
    else                ts <= ts + TS_ONE;
  end

  // Saturating count of every detection, logged or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 evt_cnt <= '0;
    else if (bus.clear)                      evt_cnt <= '0;
    else if (bus.z_det && (evt_cnt != '1))   evt_cnt <= evt_cnt + CNT_ONE;
  end

  // Sticky drop flag: a hit while full with no pop to make room is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         ovf <= 1'b0;
    else if (bus.clear)                              ovf <= 1'b0;
    else if (bus.z_det && fifo_full && !bus.rd_en)   ovf <= 1'b1;
  end

  assign bus.rd_data   = fifo_rd_data;
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.overflow  = ovf;
  assign bus.evt_count = evt_cnt;

endmodule

// File: tb/tb_mealy_event_logger.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_mealy_event_logger;
  import mealy_logger_pkg::*;

  localparam int DEPTH = 4;
  localparam int TS_W  = 5;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mealy_event_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  mealy_event_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, timestamp, hit count and drop flag from the logger's rules.
  int     m_occ = 0;
  int     m_ts  = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  entry_t exp_q[$];

  always @(posedge clk or posedge rst) begin : model
    bit              popping;
    logic [TS_W-1:0] t;
    if (rst) begin
      m_occ = 0; m_ts = 0; m_cnt = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else if (bus.clear) begin
      m_occ = 0; m_ts = 0; m_cnt = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      popping = bus.rd_en && (m_occ > 0);
      if (bus.z_det) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_occ < DEPTH || popping) begin
          t = m_ts[TS_W-1:0];
          exp_q.push_back(make_entry(bus.det_state, t));
          m_occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (popping) m_occ--;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  end

  // Monitor: compares flags every cycle and checks each word the DUT hands out on a pop.
  always @(negedge clk) begin
    if (!rst) begin
      check("empty", bus.empty, m_occ == 0);
      check("full", bus.full, m_occ == DEPTH);
      check("overflow", bus.overflow, m_ovf);
      check("evt_count", bus.evt_count, m_cnt);
      if (m_occ == 0) check("rd_data_idle", bus.rd_data, 0);
      if (bus.rd_en && !bus.empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_data: got %0h expected no entry at %0t", bus.rd_data, $time);
        end else begin
          check("pop_data", bus.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic step(input bit z, input logic [2:0] st, input bit clr, input bit rd);
    bus.z_det     = z;
    bus.det_state = st;
    bus.clear     = clr;
    bus.rd_en     = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.z_det = 1'b0; bus.det_state = 3'b000; bus.clear = 1'b0; bus.rd_en = 1'b0;

    // Reset state.
    #3;
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_evt_count", bus.evt_count, 0);
    check("rst_rd_data", bus.rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single push at ts=3 with state C.
    step(1'b0, 3'b000, 1'b1, 1'b0);
    repeat (3) step(1'b0, 3'b000, 1'b0, 1'b0);
    step(1'b1, ST_C, 1'b0, 1'b0);
    check("single_rd_data", bus.rd_data, 8'b011_00011);
    check("single_empty", bus.empty, 0);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    check("single_pop_empty", bus.empty, 1);
    check("single_pop_rd_data", bus.rd_data, 0);

    // Overflow: six hits, no reads.
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    check("ovf_full", bus.full, 1);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_evt_count", bus.evt_count, 6);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_drain_ts", bus.rd_data[TS_W-1:0], i);
      step(1'b0, 3'b000, 1'b0, 1'b1);
    end
    check("ovf_drained_empty", bus.empty, 1);
    check("ovf_sticky", bus.overflow, 1);

    // Full with simultaneous push and pop.
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    check("fpp_full_before", bus.full, 1);
    step(1'b1, ST_E, 1'b0, 1'b1);
    check("fpp_full_after", bus.full, 1);
    check("fpp_overflow", bus.overflow, 0);
    check("fpp_head_ts", bus.rd_data[TS_W-1:0], 1);
    drain();

    // Saturation and timestamp wrap with continuous draining.
    step(1'b0, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
    check("sat_evt_count", bus.evt_count, CNT_MAX);
    check("sat_overflow", bus.overflow, 0);
    drain();

    // Clear beats a simultaneous push and pop.
    step(1'b0, 3'b000, 1'b1, 1'b0);
    step(1'b1, ST_B, 1'b0, 1'b0);
    step(1'b1, ST_C, 1'b0, 1'b0);
    step(1'b1, ST_D, 1'b1, 1'b1);
    check("clr_empty", bus.empty, 1);
    check("clr_evt_count", bus.evt_count, 0);
    check("clr_overflow", bus.overflow, 0);
    step(1'b1, ST_B, 1'b0, 1'b0);
    check("clr_next_entry", bus.rd_data, {ST_B, 5'd0});
    drain();

    // Asynchronous reset with two entries queued.
    step(1'b1, ST_C, 1'b0, 1'b0);
    step(1'b1, ST_E, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_empty", bus.empty, 1);
    check("arst_evt_count", bus.evt_count, 0);
    check("arst_rd_data", bus.rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, ST_D, 1'b0, 1'b0);
    check("arst_first_entry", bus.rd_data, {ST_D, 5'd0});
    check("arst_first_count", bus.evt_count, 1);
    drain();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
